// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine: parallel operand load over valid/ready, result over valid/ready.
// Optional `GCD_CYCLES_EN adds a `cycles` output counting CALC steps of the last operation.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int KW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef GCD_CYCLES_EN
  output logic [$clog2(2*WIDTH+2)-1:0] cycles,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff;
  logic [KW-1:0]    k_q, k_d;
  logic             in_zero;

  assign in_zero = (in_a == '0) || (in_b == '0);
  // Larger minus smaller keeps the odd-odd step non-negative.
  assign diff    = (a_q > b_q) ? (a_q - b_q) : (b_q - a_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = in_zero ? DONE : CALC;
      CALC:    if (a_q == b_q) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    k_d   = k_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = in_a;
        b_d = in_b;
        k_d = '0;
        if (in_zero) res_d = in_a | in_b;
      end
      CALC: begin
        if (a_q == b_q) begin
          res_d = a_q << k_q;
        end else if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else if (!a_q[0]) begin
          a_d = a_q >> 1;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_q > b_q) begin
          a_d = diff >> 1;
        end else begin
          b_d = diff >> 1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      k_q   <= k_d;
      res_q <= res_d;
    end
  end

  assign result = res_q;

`ifdef GCD_CYCLES_EN
  localparam int CW = $clog2(2*WIDTH+2);
  logic [CW-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && in_valid) cyc_d = '0;
    else if (state_q == CALC)        cyc_d = cyc_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: per-cycle reference model plus directed literal cases and random traffic.
module tb_gcd_engine;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         busy;
`ifdef GCD_CYCLES_EN
  logic [$clog2(2*W+2)-1:0] cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  gcd_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result),
`ifdef GCD_CYCLES_EN
    .cycles(cycles),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Euclid: independent of the binary algorithm inside the DUT.
  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of CALC cycles the step rules take, including the final equality cycle.
  function automatic int ref_steps(input int unsigned x, input int unsigned y);
    int n = 0;
    if (x == 0 || y == 0) return 0;
    forever begin
      n++;
      if (x == y) return n;
      if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
      else if (x % 2 == 0) x /= 2;
      else if (y % 2 == 0) y /= 2;
      else if (x > y) x = (x - y) / 2;
      else y = (y - x) / 2;
    end
  endfunction

  // Per-cycle model: phase 0 idle, 1 computing, 2 result held.
  int           m_ph = 0;
  int           m_rem = 0;
  int           m_cyc = 0;
  logic [W-1:0] m_res = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_ph = 0;
    end else begin
      check("in_ready", in_ready, m_ph == 0);
      check("out_valid", out_valid, m_ph == 2);
      check("busy", busy, m_ph != 0);
      if (m_ph == 2) begin
        check("result", result, m_res);
`ifdef GCD_CYCLES_EN
        check("cycles", cycles, m_cyc);
`endif
      end
      case (m_ph)
        0: if (in_valid) begin
          if (in_a == 0 || in_b == 0) begin
            m_ph = 2; m_res = in_a | in_b; m_cyc = 0;
          end else begin
            m_ph = 1; m_rem = ref_steps(in_a, in_b);
            m_res = W'(ref_gcd(in_a, in_b)); m_cyc = m_rem;
            check("step_bound", m_rem <= 2*W+1, 1);
          end
        end
        1: begin
          m_rem--;
          if (m_rem == 0) m_ph = 2;
        end
        default: if (out_ready) m_ph = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, measure CALC latency, hold the result `hold` cycles while poking in_valid.
  task automatic run_pair(input int a, input int b, input int er, input int el, input int hold);
    int lat = 0;
    int g = 0;
    out_ready = 1'b0;
    while (!in_ready && g < 50) begin step(); g++; end
    check("idle_wait", in_ready, 1);
    in_valid = 1'b1; in_a = W'(a); in_b = W'(b);
    step();
    in_valid = 1'b0;
    while (!out_valid && lat < 4*W) begin step(); lat++; end
    check("latency", lat, el);
    check("res_lit", result, er);
`ifdef GCD_CYCLES_EN
    check("cycles_lit", cycles, el);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; in_a = W'($urandom); in_b = W'($urandom);
      step();
      check("bp_result", result, er);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ready_after", in_ready, 1);
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    step();
    rst = 1'b0;
    step();

    check("model_gcd", ref_gcd(143, 78), 13);
    check("model_steps", ref_steps(48, 18), 6);

    run_pair(143, 78, 13, 6, 10);
    run_pair(48, 18, 6, 6, 0);
    run_pair(18, 48, 6, ref_steps(18, 48), 0);
    run_pair(0, 77, 77, 0, 0);
    run_pair(0, 0, 0, 0, 0);
    run_pair(255, 255, 255, 1, 0);
    run_pair(128, 64, 64, ref_steps(128, 64), 0);
    run_pair(255, 254, 1, ref_steps(255, 254), 0);
    check("max_steps", ref_steps(255, 254) <= 17, 1);

    // Abort three cycles into CALC; outputs must clear before the next edge.
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    step();
    rst = 1'b0;
    step();
    run_pair(48, 18, 6, 6, 0);

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      in_b      = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      out_ready = $urandom_range(0, 1) != 0;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised successor to the serial-load GCD block.
- Accepts both operands in parallel via valid/ready, computes GCD with the binary (Stein) algorithm in at most 2*WIDTH+1 cycles, and returns the result via valid/ready with backpressure.
- Sits between an operand source (bus or FIFO) and a result consumer. It handles zero operands and reports busy.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..64).
- KW, $clog2(WIDTH+1), width of the common-power-of-two shift counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  engine can accept an operand pair.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  gcd(in_a, in_b).
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0; internal a, b, k cleared. Reset mid-CALC or mid-DONE aborts immediately; the operation is discarded.
- Three states: IDLE, CALC, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - Accept occurs on a clock edge with in_valid&in_ready. On accept, latch a=in_a, b=in_b, k=0.
  - If in_a==0 or in_b==0: result=in_a|in_b (so gcd(0,0)=0). Go directly to DONE; out_valid is high the cycle after accept.
  - Otherwise go to CALC.
- CALC: one step per cycle, evaluated in priority order:
  1. a==b: result=a<<k, go DONE.
  2. a and b both even: a>>=1, b>>=1, k+=1.
  3. a even: a>>=1.
  4. b even: b>>=1.
  5. Both odd: if a>b then a=(a-b)>>1, else b=(b-a)>>1.
- CALC arithmetic and timing rules:
  - Subtraction is WIDTH bits, never negative (larger minus smaller).
  - a and b never reach 0 in CALC.
  - a<<k never overflows WIDTH because the true GCD is ≤ min(in_a, in_b).
  - CALC lasts ≤ 2*WIDTH+1 cycles.
- DONE:
  - out_valid=1; result held stable; in_ready=0.
  - On an edge with out_ready=1: out_valid drops and the engine goes to IDLE, so in_ready rises the cycle after the result handshake.
  - There is no input/output overlap and no same-cycle re-accept.
- Input-side rules:
  - in_valid while not in_ready is ignored, and in_a/in_b are not sampled.
  - in_valid may drop before acceptance without error.
- busy = (state != IDLE).

Optional Feature:
- Macro GCD_CYCLES_EN.
- When defined: adds output port cycles, width $clog2(2*WIDTH+2).
  - cycles is cleared on accept and increments once per CALC cycle, including the final equality cycle.
  - It is held through DONE and reset to 0.
  - Zero-operand case reports 0.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, in_a=143, in_b=78, out_ready=1:
  - result=13, out_valid high 7 cycles after the accept edge (6 CALC cycles).
  - cycles=6 with GCD_CYCLES_EN.
- in_a=48, in_b=18:
  - result=6 (k=1 path exercised), 6 CALC cycles.
  - Swapping to in_a=18, in_b=48 also gives result=6.
- Zero cases:
  - (0,77) gives result=77; (0,0) gives result=0.
  - out_valid high the cycle after accept, cycles=0.
- Equal/maximum operands:
  - (255,255) gives result=255 after 1 CALC cycle.
  - (128,64) gives result=64.
  - (255,254) gives result=1, completing within 17 CALC cycles.
- Backpressure:
  - After DONE, hold out_ready=0 for 10 cycles. result stays 13, out_valid=1, in_ready=0, and in_valid pulses are ignored.
  - Raise out_ready. in_ready=1 follows on the next cycle.
  - Back-to-back pairs (143,78) then (48,18) yield 13 then 6.
- Reset mid-operation:
  - Assert rst asynchronously 3 cycles into CALC. Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, (48,18) completes correctly with result=6.
